// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding and
// default widths/limits. Used by hazard_ctrl and lu_detect.
package hazard_pkg;

    localparam int HAZARD_RA_W_DEF     = 5;
    localparam int HAZARD_MAX_WAIT_DEF = 15;

    // Encoding 2'd3 is deliberately unused; the FSM falls back to RUN from it.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } hz_state_e;

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the register
// a load in EX is about to write. Register 0 never creates a hazard.
module lu_detect
    import hazard_pkg::*;
#(
    parameter int RA_W = HAZARD_RA_W_DEF
) (
    input  logic            ex_memread,
    input  logic [RA_W-1:0] ex_rt,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rt,
    output logic            lu_hazard
);

    logic [RA_W-1:0] rs_match_bits;
    logic [RA_W-1:0] rt_match_bits;

    // Per-bit equality between the load destination and each ID source.
    generate
        for (genvar gi = 0; gi < RA_W; gi++) begin : g_cmp
            assign rs_match_bits[gi] = ~(ex_rt[gi] ^ id_rs[gi]);
            assign rt_match_bits[gi] = ~(ex_rt[gi] ^ id_rt[gi]);
        end
    endgenerate

    assign lu_hazard = ex_memread && (|ex_rt) &&
                       ((&rs_match_bits) || (id_uses_rt && (&rt_match_bits)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirects,
// data-memory wait with timeout, and debug halt/resume.
// Optional performance counters (stall_cnt, flush_cnt) are built when the
// macro HAZARD_CTRL_PERF_EN is defined; otherwise those ports do not exist.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W     = HAZARD_RA_W_DEF,
    parameter int MAX_WAIT = HAZARD_MAX_WAIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] ex_rt,
    input  logic            branch,
    input  logic            jump,
    input  logic            dmem_busy,
    input  logic            halt_req,
    input  logic            resume,
    output logic            if_write,
    output logic            id_write,
    output logic            ex_write,
    output logic            mem_write,
    output logic            pc_redirect,
    output logic            ex_bubble,
    output logic [1:0]      state,
    output logic            halted,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic            timeout_err
);

    localparam int WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    hz_state_e       state_reg, state_next;
    logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            timeout_err_reg, timeout_err_next;
    logic            lu_hazard;

    lu_detect #(.RA_W(RA_W)) u_lu_detect (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .lu_hazard  (lu_hazard)
    );

    // State, wait counter and sticky timeout flag; reset aborts any state at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // Next state and pipeline controls. Outputs are forced safe while reset is low.
    // The cycle a halt request is accepted is frozen so no instruction slips past.
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        timeout_err_next = timeout_err_reg;
        if_write         = 1'b0;
        id_write         = 1'b0;
        ex_write         = 1'b0;
        mem_write        = 1'b0;
        pc_redirect      = 1'b0;
        ex_bubble        = 1'b0;
        halted           = 1'b0;
        if (!reset) begin
            ex_bubble = 1'b1;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    wait_cnt_next = '0;
                    if (dmem_busy) begin
                        state_next = ST_MEM_WAIT;
                    end else if (halt_req) begin
                        state_next = ST_HALT;
                    end else if (lu_hazard) begin
                        ex_bubble = 1'b1;
                        ex_write  = 1'b1;
                        mem_write = 1'b1;
                    end else begin
                        if_write    = 1'b1;
                        id_write    = 1'b1;
                        ex_write    = 1'b1;
                        mem_write   = 1'b1;
                        pc_redirect = branch || jump;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!dmem_busy) begin
                        state_next    = ST_RUN;
                        wait_cnt_next = '0;
                    end else if (wait_cnt_reg == WC_W'(MAX_WAIT)) begin
                        state_next       = ST_HALT;
                        wait_cnt_next    = '0;
                        timeout_err_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WC_W'(1);
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (resume) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign state       = state_reg;
    assign timeout_err = timeout_err_reg;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Free-running event counters: frozen-fetch cycles outside HALT, and redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!if_write && (state_reg != ST_HALT)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (pc_redirect) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
// Build with HAZARD_CTRL_PERF_EN defined to also cover the perf counters.
module tb_hazard_ctrl;

    localparam int RA_W     = 5;
    localparam int MAX_WAIT = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [RA_W-1:0] id_rs, id_rt, ex_rt;
    logic            id_uses_rt, ex_memread, branch, jump;
    logic            dmem_busy, halt_req, resume;
    logic            if_write, id_write, ex_write, mem_write;
    logic            pc_redirect, ex_bubble, halted, timeout_err;
    logic [1:0]      state;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0]     stall_cnt, flush_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model state
    int          m_state;   // 0 run, 1 waiting on memory, 2 halted
    int          m_wait;    // busy cycles already spent waiting
    bit          m_tout;
    logic [31:0] m_stall, m_flush;
    bit          e_if, e_id, e_ex, e_mem, e_pc, e_bub, e_halt, e_bub_def;
    int          busy_hold;

    always #5 clk = ~clk;

    hazard_ctrl #(.RA_W(RA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rt       (ex_rt),
        .branch      (branch),
        .jump        (jump),
        .dmem_busy   (dmem_busy),
        .halt_req    (halt_req),
        .resume      (resume),
        .if_write    (if_write),
        .id_write    (id_write),
        .ex_write    (ex_write),
        .mem_write   (mem_write),
        .pc_redirect (pc_redirect),
        .ex_bubble   (ex_bubble),
        .state       (state),
        .halted      (halted),
`ifdef HAZARD_CTRL_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_tout  = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    // Expected outputs from the rules: busy and halt freeze everything,
    // a load-use conflict holds IF/ID and bubbles EX, otherwise all advance.
    task automatic model_outputs();
        bit lu;
        lu = ex_memread && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        {e_if, e_id, e_ex, e_mem, e_pc, e_bub, e_halt} = '0;
        e_bub_def = 1'b0;
        if (!reset) begin
            e_bub     = 1'b1;
            e_bub_def = 1'b1;
        end else if (m_state == 2) begin
            e_halt = 1'b1;
        end else if (m_state == 0 && !dmem_busy && !halt_req) begin
            e_bub_def = 1'b1;
            if (lu) begin
                e_ex  = 1'b1;
                e_mem = 1'b1;
                e_bub = 1'b1;
            end else begin
                {e_if, e_id, e_ex, e_mem} = 4'b1111;
                e_pc = branch || jump;
            end
        end
    endtask

    task automatic model_update();
        if (!reset) begin
            model_reset();
        end else begin
            if (!e_if && m_state != 2) m_stall = m_stall + 1;
            if (e_pc) m_flush = m_flush + 1;
            case (m_state)
                0: begin
                    if (dmem_busy) m_state = 1;
                    else if (halt_req) m_state = 2;
                end
                1: begin
                    if (!dmem_busy) begin
                        m_state = 0;
                        m_wait  = 0;
                    end else if (m_wait == MAX_WAIT) begin
                        m_state = 2;
                        m_tout  = 1'b1;
                        m_wait  = 0;
                    end else begin
                        m_wait++;
                    end
                end
                default: begin
                    if (resume) m_state = 0;
                end
            endcase
        end
    endtask

    // The single compare point: every cycle, on the falling edge.
    task automatic sample();
        @(negedge clk);
        model_outputs();
        chk("state",       32'(state),       32'(m_state));
        chk("if_write",    32'(if_write),    32'(e_if));
        chk("id_write",    32'(id_write),    32'(e_id));
        chk("ex_write",    32'(ex_write),    32'(e_ex));
        chk("mem_write",   32'(mem_write),   32'(e_mem));
        chk("pc_redirect", 32'(pc_redirect), 32'(e_pc));
        chk("halted",      32'(halted),      32'(e_halt));
        chk("timeout_err", 32'(timeout_err), 32'(m_tout));
        if (e_bub_def) chk("ex_bubble", 32'(ex_bubble), 32'(e_bub));
`ifdef HAZARD_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_idle();
        id_rs      = '0;
        id_rt      = '0;
        ex_rt      = '0;
        id_uses_rt = 1'b0;
        ex_memread = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        dmem_busy  = 1'b0;
        halt_req   = 1'b0;
        resume     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        model_reset();
        busy_hold = 0;
        #1 reset = 1'b0;

        // Reset values
        sample();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_bubble", 32'(ex_bubble), 32'd1);
        chk("rst_if_write", 32'(if_write), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        advance();
        sample();
        advance();
        reset = 1'b1;
        $display("txn reset released");

        // Load-use on rs
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        sample();
        chk("lu_if_write", 32'(if_write), 32'd0);
        chk("lu_id_write", 32'(id_write), 32'd0);
        chk("lu_bubble", 32'(ex_bubble), 32'd1);
        advance();
        ex_memread = 1'b0;
        sample();
        chk("lu_done_if_write", 32'(if_write), 32'd1);
        advance();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        sample();
        chk("lu_r0_if_write", 32'(if_write), 32'd1);
        advance();
        $display("txn load-use");

        // Branch behind a load-use
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; branch = 1'b1;
        sample();
        chk("br_lu_redirect", 32'(pc_redirect), 32'd0);
        advance();
        ex_memread = 1'b0;
        sample();
        chk("br_redirect", 32'(pc_redirect), 32'd1);
        advance();
        drive_idle();
        $display("txn branch behind load-use");

        // Three-cycle memory wait
        dmem_busy = 1'b1;
        sample();
        chk("mw_run_if_write", 32'(if_write), 32'd0);
        advance();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) dmem_busy = 1'b0;
            sample();
            chk("mw_state", 32'(state), 32'd1);
            chk("mw_mem_write", 32'(mem_write), 32'd0);
            advance();
        end
        sample();
        chk("mw_back_state", 32'(state), 32'd0);
        advance();
        $display("txn memory wait");

        // Timeout: busy for MAX_WAIT+2 cycles
        dmem_busy = 1'b1;
        for (int k = 0; k < MAX_WAIT + 2; k++) begin
            sample();
            advance();
        end
        dmem_busy = 1'b0;
        sample();
        chk("to_state", 32'(state), 32'd2);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_halted", 32'(halted), 32'd1);
        resume = 1'b1;
        advance();
        resume = 1'b0;
        sample();
        chk("to_resumed_state", 32'(state), 32'd0);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        advance();
        $display("txn timeout");

        // Halt request together with busy is dropped; a later one halts
        halt_req = 1'b1; dmem_busy = 1'b1;
        sample();
        advance();
        halt_req = 1'b0; dmem_busy = 1'b0;
        sample();
        chk("hb_state", 32'(state), 32'd1);
        advance();
        sample();
        chk("hb_run_state", 32'(state), 32'd0);
        advance();
        halt_req = 1'b1;
        sample();
        advance();
        sample();
        chk("hb_halt_state", 32'(state), 32'd2);
        chk("hb_halted", 32'(halted), 32'd1);
        advance();
        halt_req = 1'b0; resume = 1'b1;
        sample();
        advance();
        resume = 1'b0;
        sample();
        chk("hb_resume_state", 32'(state), 32'd0);
        advance();
        $display("txn halt with busy");

        // Asynchronous reset in the middle of a memory wait
        dmem_busy = 1'b1;
        sample();
        advance();
        sample();
        chk("ar_pre_state", 32'(state), 32'd1);
        advance();
        #2 reset = 1'b0;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_bubble", 32'(ex_bubble), 32'd1);
`ifdef HAZARD_CTRL_PERF_EN
        chk("ar_stall_cnt", stall_cnt, 32'd0);
        chk("ar_flush_cnt", flush_cnt, 32'd0);
`endif
        model_reset();
        sample();
        advance();
        reset = 1'b1;
        dmem_busy = 1'b0;
        sample();
        chk("ar_after_state", 32'(state), 32'd0);
        advance();
        $display("txn async reset");

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            if (busy_hold > 0) begin
                dmem_busy = 1'b1;
                busy_hold--;
            end else begin
                dmem_busy = ($urandom_range(0, 99) < 15);
                if ($urandom_range(0, 99) < 3) busy_hold = $urandom_range(10, MAX_WAIT + 4);
            end
            halt_req   = ($urandom_range(0, 99) < 4);
            resume     = ($urandom_range(0, 99) < 20);
            ex_memread = 1'($urandom_range(0, 1));
            ex_rt      = RA_W'($urandom_range(0, 3));
            id_rs      = RA_W'($urandom_range(0, 3));
            id_rt      = RA_W'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            branch     = ($urandom_range(0, 99) < 20);
            jump       = ($urandom_range(0, 99) < 10);
            sample();
            $display("txn rnd %0d st=%0d busy=%0b halt=%0b res=%0b ifw=%0b redir=%0b", c,
                     state, dmem_busy, halt_req, resume, if_write, pc_redirect);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter RA_W, default 5: register-address width.
REQ-002 Parameter MAX_WAIT, default 15: longest data-memory busy run, in cycles, before timeout.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  in  RA_W each  source registers of the instruction in ID.
REQ-006 id_uses_rt  in  1  the ID instruction reads rt.
REQ-007 ex_memread, ex_rt  in  1, RA_W  the EX instruction is a load, and its destination register.
REQ-008 branch, jump  in  1 each  taken branch or jump resolved in ID.
REQ-009 dmem_busy  in  1  data memory is not ready this cycle.
REQ-010 halt_req, resume  in  1 each  single-cycle debug pulses.
REQ-011 if_write, id_write, ex_write, mem_write  out  1 each  pipeline-register write enables.
REQ-012 pc_redirect  out  1  IF loads the jump address; doubles as the IF/ID flush.
REQ-013 ex_bubble  out  1  zero the ID/EX control fields.
REQ-014 state  out  2  current FSM state.
REQ-015 halted, timeout_err  out  1 each  halt indication; sticky timeout flag.

Function
REQ-016 FSM states SHALL be RUN=0, MEM_WAIT=1, HALT=2; encoding 3 is unused and SHALL go to RUN.
REQ-017 lu_hazard SHALL be ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)), evaluated combinationally.
REQ-018 In RUN with dmem_busy=0 and lu_hazard=1: if_write=0, id_write=0, ex_bubble=1, ex_write=1, mem_write=1, pc_redirect=0; the stall lasts one cycle with no extra state.
REQ-019 In RUN with dmem_busy=0, lu_hazard=0 and (branch||jump): pc_redirect=1 and all write enables=1, in the same cycle.
REQ-020 lu_hazard SHALL take priority over branch/jump; the redirect waits until the operand is available.
REQ-021 In RUN with no hazard and no redirect: all write enables=1, pc_redirect=0, ex_bubble=0.
REQ-022 RUN with dmem_busy=1 -> MEM_WAIT on the next edge; all write enables=0 and pc_redirect=0 in that same cycle.
REQ-023 In MEM_WAIT: all write enables=0 and pc_redirect=0; wait_cnt (width clog2(MAX_WAIT+1)) increments every cycle dmem_busy=1.
REQ-024 MEM_WAIT with dmem_busy=0 -> RUN, and wait_cnt clears.
REQ-025 MEM_WAIT with wait_cnt==MAX_WAIT and dmem_busy=1 -> HALT, and timeout_err sets.
REQ-026 RUN with halt_req=1 and dmem_busy=0 -> HALT; a halt_req in the same cycle as dmem_busy SHALL be ignored (busy wins).
REQ-027 In HALT: all write enables=0 and halted=1; resume=1 -> RUN, and halt_req is ignored.
REQ-028 timeout_err SHALL clear only on reset.
REQ-029 Priority in RUN, highest first: dmem_busy, halt_req, lu_hazard, branch/jump.

Reset
REQ-030 While reset=0: state=RUN, wait_cnt=0, timeout_err=0, halted=0, all write enables=0, pc_redirect=0, ex_bubble=1.
REQ-031 Reset asserted mid-MEM_WAIT or mid-HALT SHALL abort immediately (asynchronous); the first edge after release evaluates RUN rules.

Configuration
REQ-032 Macro HAZARD_CTRL_PERF_EN defined: add outputs stall_cnt (32) and flush_cnt (32).
REQ-033 stall_cnt counts cycles with if_write=0 while state!=HALT; flush_cnt counts cycles with pc_redirect=1; both wrap at 2^32 and reset to 0.
REQ-034 Macro HAZARD_CTRL_PERF_EN undefined: those ports and counters SHALL be absent; behaviour is otherwise identical.

Structure
REQ-035 Package hazard_pkg SHALL hold the state encoding constants, RA_W default and MAX_WAIT default.
REQ-036 Sub-module lu_detect SHALL hold the combinational lu_hazard comparator; the FSM and counters SHALL live in hazard_ctrl.

Verification
REQ-037 Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> one cycle of if_write=0, id_write=0, ex_bubble=1; ex_rt=0 -> no stall.
REQ-038 Branch behind load-use: branch=1 with lu_hazard=1 -> pc_redirect=0 that cycle, pc_redirect=1 the next cycle.
REQ-039 Memory wait: dmem_busy high for 3 cycles -> state=1 for 3 cycles with all enables 0, then state=0.
REQ-040 Timeout: dmem_busy held for MAX_WAIT+2 cycles -> state=2 and timeout_err=1; resume pulse -> state=0 with timeout_err still 1.
REQ-041 Halt with busy: halt_req and dmem_busy together -> MEM_WAIT and halt ignored; a later halt_req -> HALT; resume -> RUN.
REQ-042 Async reset: drive reset low mid-MEM_WAIT between edges -> state=0 and ex_bubble=1 immediately; with HAZARD_CTRL_PERF_EN, both counters read 0.
